add: RTL and testbench

// - 32-bit unsigned two-operand adder built as a hierarchical carry-lookahead

---
 rtl/add.sv | 80 ++++++++
 tb/tb_add.sv | 111 +++++++++++
 2 files changed

// File: rtl/add.sv
// 32-bit unsigned adder: three-level carry-lookahead core with a registered
// sum/carry output stage. Carry-in is tied to zero.
module add (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic        carry
);

    localparam int unsigned W  = 32;
    localparam int unsigned GW = 4;
    localparam int unsigned NG = W / GW;
    localparam int unsigned NB = 2;

    // 4-wide lookahead: returns {G, P, c3, c2, c1} from generate/propagate and carry-in
    function automatic logic [4:0] la4(input logic [3:0] gi, input logic [3:0] pi, input logic cin);
        logic c1, c2, c3, go, po;
        c1 = gi[0] | (pi[0] & cin);
        c2 = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & cin);
        c3 = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0]) | (pi[2] & pi[1] & pi[0] & cin);
        go = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1]) | (pi[3] & pi[2] & pi[1] & gi[0]);
        po = &pi;
        return {go, po, c3, c2, c1};
    endfunction

    logic [W-1:0]  g;
    logic [W-1:0]  p;
    logic [W-1:0]  c;      // carry into each bit
    logic [NG-1:0] grp_g;
    logic [NG-1:0] grp_p;
    logic [NG-1:0] grp_c;  // carry into each 4-bit group
    logic [NB-1:0] blk_g;
    logic [NB-1:0] blk_p;
    logic [NB-1:0] blk_c;  // carry into each 16-bit block
    logic          c32;
    logic [W-1:0]  sum_c;

    // Bit-level generate/propagate
    assign g = a & b;
    assign p = a ^ b;

    // Level 1: eight 4-bit groups produce internal carries and group G/P
    for (genvar k = 0; k < int'(NG); k++) begin : g_grp
        logic [4:0] r;
        assign r               = la4(g[GW*k +: GW], p[GW*k +: GW], grp_c[k]);
        assign c[GW*k +: GW]   = {r[2:0], grp_c[k]};
        assign grp_g[k]        = r[4];
        assign grp_p[k]        = r[3];
    end

    // Level 2: two 16-bit units produce group carry-ins and block G/P
    for (genvar j = 0; j < int'(NB); j++) begin : g_blk
        logic [4:0] r;
        assign r                 = la4(grp_g[4*j +: 4], grp_p[4*j +: 4], blk_c[j]);
        assign grp_c[4*j +: 4]   = {r[2:0], blk_c[j]};
        assign blk_g[j]          = r[4];
        assign blk_p[j]          = r[3];
    end

    // Level 3: top lookahead across the two blocks, carry-in fixed at zero
    assign blk_c[0] = 1'b0;
    assign blk_c[1] = blk_g[0] | (blk_p[0] & blk_c[0]);
    assign c32      = blk_g[1] | (blk_p[1] & blk_c[1]);

    assign sum_c = p ^ c;

    // Output register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sum   <= '0;
            carry <= 1'b0;
        end else begin
            sum   <= sum_c;
            carry <= c32;
        end
    end

endmodule

// File: tb/tb_add.sv
// Self-checking bench for the registered 32-bit CLA adder.
module tb_add;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
    logic        carry;

    int checks;
    int errors;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_sum;
        logic        exp_carry;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    add dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .sum   (sum),
        .carry (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] es, input logic ec);
        checks++;
        if (sum !== es || carry !== ec) begin
            errors++;
            $display("FAIL %s: got sum=%h carry=%b, expected sum=%h carry=%b",
                     name, sum, carry, es, ec);
        end
    endtask

    // Drive inputs away from the edge, clock once, sample 1 time unit after
    task automatic step(input logic r, input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        rst = r;
        a   = va;
        b   = vb;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [32:0] ref33;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        a   = '0;
        b   = '0;

        vecs[0]  = '{32'd15,        32'd10,        32'd25,         1'b0};
        vecs[1]  = '{32'd123456789, 32'd987654321, 32'd1111111110, 1'b0};
        vecs[2]  = '{32'hFFFF_FFFF, 32'd1,         32'h0000_0000,  1'b1};
        vecs[3]  = '{32'h0000_FFFF, 32'd1,         32'h0001_0000,  1'b0};
        vecs[4]  = '{32'd0,         32'd0,         32'd0,          1'b0};
        vecs[5]  = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000,  1'b1};
        vecs[6]  = '{32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'hFFFF_FFFF,  1'b0};
        vecs[7]  = '{32'h7FFF_FFFF, 32'd1,         32'h8000_0000,  1'b0};
        vecs[8]  = '{32'h0000_000F, 32'd1,         32'h0000_0010,  1'b0};
        vecs[9]  = '{32'h00FF_FFFF, 32'h0000_0001, 32'h0100_0000,  1'b0};
        vecs[10] = '{32'hDEAD_BEEF, 32'hCAFE_BABE, 32'hA9AC_79AD,  1'b1};

        // Reset held for two edges with live operands
        step(1'b1, 32'd5, 32'd7);
        check("reset_edge1", 32'd0, 1'b0);
        step(1'b1, 32'd5, 32'd7);
        check("reset_edge2", 32'd0, 1'b0);

        // Directed vectors, back to back
        for (int i = 0; i < NV; i++) begin
            step(1'b0, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d", i), vecs[i].exp_sum, vecs[i].exp_carry);
        end

        // Max + max, then reset mid-stream, then recovery
        step(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("max_plus_max", 32'hFFFF_FFFE, 1'b1);
        step(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("midstream_reset", 32'd0, 1'b0);
        step(1'b0, 32'd1, 32'd2);
        check("after_reset", 32'd3, 1'b0);

        // Random pairs against a 33-bit reference sum
        for (int i = 0; i < 10000; i++) begin
            ra    = $urandom;
            rb    = $urandom;
            ref33 = {1'b0, ra} + {1'b0, rb};
            step(1'b0, ra, rb);
            check("random", ref33[31:0], ref33[32]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
